// File: rtl/chip_bus_arbiter.sv
// ---------------------------------------------------------------------------
// chip_bus_arbiter
//
// Round-robin arbiter that shares the single chip_bus among NUM_REQ masters.
// A master drives the bus only while its grant bit is high. Each ownership is
// limited to MAX_HOLD consecutive cycles (0 = unlimited). At least one dead
// cycle with no grant separates two owners, so bus drivers never overlap.
//
// Parameters:
//   NUM_REQ   number of requesting masters (1..16)
//   MAX_HOLD  maximum consecutive granted cycles per ownership, 0 = no limit
//   ID_W      width of the owner index (derived)
//
// Ports:
//   clock     system clock, all state changes on the rising edge
//   reset     synchronous, active-high reset
//   req       level request vector, bit i belongs to master i
//   gnt       registered one-hot-or-zero grant vector
//   owner     index of the current or most recent owner
//   bus_busy  high whenever any grant is high
//   timeout   one-cycle pulse when an ownership is forcibly revoked
// ---------------------------------------------------------------------------
module chip_bus_arbiter #(
  parameter int  NUM_REQ  = 4,
  parameter int  MAX_HOLD = 8,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    owner,
  output logic               bus_busy,
  output logic               timeout
);

  // Counter only has to reach MAX_HOLD-1; it saturates at all-ones.
  localparam int                CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [ID_W-1:0]   LAST_RST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_TURN
  } state_t;

  state_t               state_q,    state_d;
  logic [NUM_REQ-1:0]   gnt_q,      gnt_d;
  logic [ID_W-1:0]      owner_q,    owner_d;
  logic [ID_W-1:0]      last_q,     last_d;
  logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic                 timeout_q,  timeout_d;
  logic                 busy_q,     busy_d;

  logic                 arb_found;
  logic [ID_W-1:0]      arb_idx;

  // Index that lies k positions after base, wrapping at NUM_REQ.
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Round-robin scan: start just after the last winner so it ends up with
  // the lowest priority, and the first requesting index wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise
    // paths that skip an assignment would infer a latch.
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!arb_found && req[wrap_idx(last_q, k)]) begin
        arb_found = 1'b1;
        arb_idx   = wrap_idx(last_q, k);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;

    unique case (state_q)
      // IDLE and TURN arbitrate identically; TURN exists only so that a
      // release is always followed by at least one cycle with gnt=0.
      S_IDLE, S_TURN: begin
        gnt_d = '0;
        if (arb_found) begin
          gnt_d[arb_idx] = 1'b1;
          owner_d        = arb_idx;
          last_d         = arb_idx;
          hold_cnt_d     = '0;
          state_d        = S_GRANT;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_GRANT: begin
        // A voluntary release takes precedence over the timeout.
        if (!req[owner_q]) begin
          gnt_d   = '0;
          state_d = S_TURN;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST)) begin
          gnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = S_TURN;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = |gnt_d;
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      last_q     <= LAST_RST;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt      = gnt_q;
  assign owner    = owner_q;
  assign bus_busy = busy_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_chip_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_chip_bus_arbiter
//
// Self-checking bench for chip_bus_arbiter (NUM_REQ=4, MAX_HOLD=8).
// A fixed vector table covers reset and round-robin rotation, hand-written
// sequences cover timeout, late release and reset during a grant, and a long
// random run is compared cycle by cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_chip_bus_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int MAX_HOLD = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       bus_busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  chip_bus_arbiter #(
    .NUM_REQ (NUM_REQ),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .owner   (owner),
    .bus_busy(bus_busy),
    .timeout (timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Behavioural model: who owns the bus and for how many visible cycles.
  // No owner means the next edge arbitrates.
  // -------------------------------------------------------------------------
  int m_own;        // current owner, -1 when nobody holds the bus
  int m_held;       // cycles the current owner has seen its grant
  int m_last;       // last winner for the round-robin rotation
  int m_owner_out;  // value expected on the owner port
  bit m_to;         // expected timeout pulse

  function automatic void model_reset();
    m_own       = -1;
    m_held      = 0;
    m_last      = NUM_REQ - 1;
    m_owner_out = 0;
    m_to        = 1'b0;
  endfunction

  function automatic void model_edge(input logic [3:0] r);
    m_to = 1'b0;
    if (m_own >= 0) begin
      if (!r[m_own]) begin
        m_own = -1;
      end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
        m_own = -1;
        m_to  = 1'b1;
      end else begin
        m_held++;
      end
    end else begin
      for (int off = 1; off <= NUM_REQ; off++) begin
        int i;
        i = (m_last + off) % NUM_REQ;
        if (r[i]) begin
          m_own       = i;
          m_last      = i;
          m_owner_out = i;
          m_held      = 1;
          break;
        end
      end
    end
  endfunction

  function automatic logic [3:0] model_gnt();
    logic [3:0] g;
    g = 4'b0000;
    if (m_own >= 0) g[m_own] = 1'b1;
    return g;
  endfunction

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b required %b ({gnt,owner,busy,timeout} or flag)",
               name, act, exp);
    end
  endtask

  task automatic exp_out(input string name, input logic [3:0] g, input logic [1:0] o,
                         input logic t);
    check(name, {gnt, owner, bus_busy, timeout}, {g, o, |g, t});
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    tick();
    exp_out(name, 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] o,
                     input int n);
    vec_t v;
    v.req   = r;
    v.gnt   = g;
    v.owner = o;
    v.to    = 1'b0;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  initial begin
    logic [3:0] r;
    logic [3:0] prev_g;
    bit         do_rst;

    // Idle, then full rotation 0,1,2,3,0 with 3-cycle grants and one dead cycle.
    add(4'b0000, 4'b0000, 2'd0, 5);
    add(4'b1111, 4'b0001, 2'd0, 3);
    add(4'b1110, 4'b0000, 2'd0, 1);
    add(4'b1110, 4'b0010, 2'd1, 3);
    add(4'b1100, 4'b0000, 2'd1, 1);
    add(4'b1100, 4'b0100, 2'd2, 3);
    add(4'b1000, 4'b0000, 2'd2, 1);
    add(4'b1000, 4'b1000, 2'd3, 3);
    add(4'b0001, 4'b0000, 2'd3, 1);
    add(4'b0001, 4'b0001, 2'd0, 3);
    add(4'b0000, 4'b0000, 2'd0, 2);

    do_reset("reset_state");
    for (int i = 0; i < vecs.size(); i++) begin
      req = vecs[i].req;
      tick();
      exp_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].owner, vecs[i].to);
    end

    // Forced release: master 2 holds 8 cycles, then timeout, dead cycle, master 1.
    do_reset("reset_to");
    req = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) req = 4'b0110;
      tick();
      exp_out($sformatf("to_hold%0d", k), 4'b0100, 2'd2, 1'b0);
    end
    tick();
    exp_out("to_pulse", 4'b0000, 2'd2, 1'b1);
    tick();
    exp_out("to_next", 4'b0010, 2'd1, 1'b0);
    req = 4'b0000;
    tick();
    exp_out("to_release", 4'b0000, 2'd1, 1'b0);

    // Release sampled on the same edge the timeout would fire: no pulse.
    do_reset("reset_late");
    req = 4'b1000;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_out($sformatf("late_hold%0d", k), 4'b1000, 2'd3, 1'b0);
    end
    req = 4'b0000;
    tick();
    exp_out("late_release", 4'b0000, 2'd3, 1'b0);
    req = 4'b1000;
    tick();
    exp_out("late_regrant", 4'b1000, 2'd3, 1'b0);
    req = 4'b0000;
    tick();

    // Reset during the second cycle of a grant to master 1.
    do_reset("reset_mid");
    req = 4'b0010;
    tick();
    exp_out("rmid_grant", 4'b0010, 2'd1, 1'b0);
    req = 4'b0011;
    tick();
    exp_out("rmid_hold", 4'b0010, 2'd1, 1'b0);
    reset = 1'b1;
    tick();
    exp_out("rmid_reset", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;
    tick();
    exp_out("rmid_pointer", 4'b0001, 2'd0, 1'b0);

    // Random requests against the model, with occasional resets.
    req = 4'b0000;
    do_reset("reset_rand");
    model_reset();
    r      = 4'b0000;
    prev_g = 4'b0000;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      do_rst = ($urandom_range(0, 399) == 0);
      for (int b = 0; b < NUM_REQ; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      req   = r;
      reset = do_rst;
      tick();
      if (do_rst) model_reset();
      else        model_edge(r);
      exp_out($sformatf("rand%0d", cyc), model_gnt(), 2'(m_owner_out), m_to);
      check($sformatf("onehot0_%0d", cyc), {7'd0, $onehot0(gnt)}, 8'd1);
      check($sformatf("dead_cycle_%0d", cyc),
            {7'd0, (gnt != 4'b0000) && (prev_g != 4'b0000) && (gnt != prev_g)}, 8'd0);
      prev_g = gnt;
    end
    reset = 1'b0;
    req   = 4'b0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chip_bus_arbiter.md
Name: chip_bus_arbiter

Overview:
- Round-robin arbiter that shares the single `chip_bus` instance among up to NUM_REQ bus masters, e.g. CACHE, DMA and test port.
- Sits in `top` next to the `chip_bus` instance. Each master raises a request and drives the bus only while its grant is high.
- Enforces a maximum ownership time and one dead (turnaround) cycle between owners, so two masters never drive the bus in the same cycle.

Parameters:
- NUM_REQ, 4, number of requesting masters (1..16).
- MAX_HOLD, 8, maximum consecutive granted cycles per ownership; 0 disables the timeout.
- ID_W, $clog2(NUM_REQ) with a minimum of 1, width of the owner index (derived, not overridden).

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  request vector, bit i = master i; level-sensitive, held while ownership is wanted.
- gnt  output  NUM_REQ  registered one-hot-or-zero grant vector.
- owner  output  ID_W  index of the current or most recent owner.
- bus_busy  output  1  equals |gnt.
- timeout  output  1  one-cycle pulse when an ownership is forcibly revoked.

Behaviour:
- Reset (reset high at an edge):
  - gnt=0, owner=0, bus_busy=0, timeout=0, state=IDLE, hold_cnt=0.
  - Round-robin pointer last=NUM_REQ-1, so master 0 has top priority after reset.
  - Reset asserted mid-grant drops gnt at that same edge; no timeout pulse.
- States: IDLE, GRANT, TURN. All outputs are registered.
- Arbitration (evaluated in IDLE and TURN):
  - Scan req starting at index (last+1) mod NUM_REQ and wrap around; the first set bit wins.
  - At that edge: gnt←onehot(winner), owner←winner, last←winner, hold_cnt←0, state←GRANT.
  - Grant latency: gnt is visible the cycle after req is first sampled in IDLE.
  - If no req, gnt stays 0 and state←IDLE.
- GRANT:
  - hold_cnt increments each edge. req bits of non-owners are ignored.
  - Normal release: req[owner] sampled low → gnt←0, state←TURN, timeout stays 0.
  - Forced release: MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1 with req[owner] still high → gnt←0, timeout←1 for one cycle, state←TURN. The owner therefore holds gnt exactly MAX_HOLD cycles.
  - Release and timeout on the same edge: the release wins, no timeout pulse.
  - hold_cnt saturates; it never wraps.
- TURN:
  - Lasts exactly one cycle with gnt=0, giving one dead cycle between owners.
  - Arbitration is performed at the edge leaving TURN, so the next gnt is visible on the following cycle, or state←IDLE if there is no req.
  - A forcibly released master whose req is still high competes again at lowest priority, because last equals its index.
- Invariants: $onehot0(gnt) every cycle; gnt never changes owner without passing through a gnt=0 cycle; bus_busy==|gnt.
- Special cases:
  - NUM_REQ=1: the master is re-granted after each TURN cycle.
  - MAX_HOLD=1: the owner gets one cycle, then TURN.

Test Plan:
- Reset then req=4'b0000 for 5 cycles → gnt=0, bus_busy=0, owner=0, timeout=0 throughout.
- req=4'b1111 from cycle 0; each owner drops its req 3 cycles after its grant → grants in order 0,1,2,3,0. Each grant is high 3 cycles, followed by exactly 1 cycle of gnt=0.
- req[2] held high continuously, MAX_HOLD=8, req[1] raised at cycle 4 → gnt=4'b0100 for 8 cycles, timeout=1 for one cycle as gnt drops, one dead cycle, then gnt=4'b0010.
- req[3] drops on the same edge its hold_cnt reaches 7 (MAX_HOLD=8) → gnt drops, timeout stays 0, state goes to TURN.
- reset asserted on the 2nd cycle of a grant to master 1, with req=4'b0011 held → gnt=0 next cycle. After reset releases, master 0 is granted first because the pointer was restored.
- Random req for 10k cycles → $onehot0(gnt) always holds, and every owner change has ≥1 gnt=0 cycle between grants.
